// File: rtl/sdram_inport_arb_if.sv
// Bus bundle between the requesters, the input-port arbiter and the SDRAM core request port.
// Requester side: req_wr_i/req_rd_i/req_len_i/req_addr_i/req_wdata_i in, and
//   req_accept_o/req_ack_o/req_error_o/req_rdata_o out (all packed per requester except rdata).
// Core side: ram_wr_o/ram_rd_o/ram_len_o/ram_addr_o/ram_wdata_o out, and
//   ram_accept_i/ram_ack_i/ram_error_i/ram_rdata_i in.
// Modport slave is the arbiter's view; modport master is the environment's view.
interface sdram_inport_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ*DATA_W/8-1:0] req_wr_i;
  logic [NUM_REQ-1:0]          req_rd_i;
  logic [NUM_REQ*8-1:0]        req_len_i;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i;
  logic [NUM_REQ-1:0]          req_accept_o;
  logic [NUM_REQ-1:0]          req_ack_o;
  logic [NUM_REQ-1:0]          req_error_o;
  logic [DATA_W-1:0]           req_rdata_o;

  logic [DATA_W/8-1:0]         ram_wr_o;
  logic                        ram_rd_o;
  logic [7:0]                  ram_len_o;
  logic [ADDR_W-1:0]           ram_addr_o;
  logic [DATA_W-1:0]           ram_wdata_o;
  logic                        ram_accept_i;
  logic                        ram_ack_i;
  logic                        ram_error_i;
  logic [DATA_W-1:0]           ram_rdata_i;

  modport slave (
    input  req_wr_i, req_rd_i, req_len_i, req_addr_i, req_wdata_i,
    output req_accept_o, req_ack_o, req_error_o, req_rdata_o,
    output ram_wr_o, ram_rd_o, ram_len_o, ram_addr_o, ram_wdata_o,
    input  ram_accept_i, ram_ack_i, ram_error_i, ram_rdata_i
  );

  modport master (
    output req_wr_i, req_rd_i, req_len_i, req_addr_i, req_wdata_i,
    input  req_accept_o, req_ack_o, req_error_o, req_rdata_o,
    input  ram_wr_o, ram_rd_o, ram_len_o, ram_addr_o, ram_wdata_o,
    output ram_accept_i, ram_ack_i, ram_error_i, ram_rdata_i
  );
endinterface

// File: rtl/sdram_inport_arb.sv
// Round-robin arbiter sharing one SDRAM core request port between NUM_REQ requesters.
// A grant is locked until the core accepts it; an in-order ID FIFO routes each core
// ack/error/rdata back to the requester whose request it answers.
// Ports: clk, rst (sync, active high); bus (slave view of sdram_inport_arb_if);
//   busy_o (FIFO non-empty or request presented); proto_err_o (sticky protocol error).
module sdram_inport_arb #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_inport_arb_if.slave    bus,
  output logic                 busy_o,
  output logic                 proto_err_o
);

  localparam int StrbW = int'(DATA_W / 8);
  localparam int NReq  = int'(NUM_REQ);
  localparam int AW    = int'(ADDR_W);
  localparam int DW    = int'(DATA_W);
  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e               st_q, st_d;
  logic [IdW-1:0]       gnt_q, gnt_d;
  logic [IdW-1:0]       rr_q, rr_d;
  logic [IdW-1:0]       fifo_q [MAX_OUTST];
  logic [IdW-1:0]       fifo_d [MAX_OUTST];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 proto_err_q, proto_err_d;

  logic [NUM_REQ-1:0]   pending;
  logic [IdW-1:0]       rr_sel, sel, head;
  logic                 rr_found, sel_valid, presented, accept, pop, full, empty;
  logic [StrbW-1:0]     sel_wr;
  logic                 sel_rd;
  logic [7:0]           sel_len;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [NUM_REQ-1:0]   accept_vec, ack_vec, err_vec;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NReq; i++) begin
      pending[i] = (|bus.req_wr_i[i*StrbW +: StrbW]) | bus.req_rd_i[i];
    end
  end

  // First pending index at or after rr_q; scanning downward lets the lowest offset win.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int k = NReq - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_q) + k) % NReq;
      if (pending[idx]) begin
        rr_found = 1'b1;
        rr_sel   = IdW'(idx);
      end
    end
  end

  assign full      = (count_q == CntW'(MAX_OUTST));
  assign empty     = (count_q == '0);
  assign sel       = (st_q == StLocked) ? gnt_q : rr_sel;
  assign sel_valid = (st_q == StLocked) | rr_found;
  assign head      = fifo_q[rptr_q];

  always_comb begin
    int s;
    s         = int'(sel);
    sel_wr    = bus.req_wr_i[s*StrbW +: StrbW];
    sel_rd    = bus.req_rd_i[s];
    sel_len   = bus.req_len_i[s*8 +: 8];
    sel_addr  = bus.req_addr_i[s*AW +: AW];
    sel_wdata = bus.req_wdata_i[s*DW +: DW];
  end

  // A locked requester that drops its request is simply not presented; lock stays.
  assign presented = ~rst & sel_valid & pending[sel] & ~full;
  assign accept    = presented & bus.ram_accept_i;
  assign pop       = ~rst & bus.ram_ack_i & ~empty;

  always_comb begin
    accept_vec = '0;
    ack_vec    = '0;
    err_vec    = '0;
    if (accept) accept_vec[sel] = 1'b1;
    if (pop) begin
      ack_vec[head] = 1'b1;
      err_vec[head] = bus.ram_error_i;
    end
  end

  assign bus.req_accept_o = accept_vec;
  assign bus.req_ack_o    = ack_vec;
  assign bus.req_error_o  = err_vec;
  assign bus.req_rdata_o  = rst ? '0 : bus.ram_rdata_i;

  // Write wins when a requester raises strobes and rd together.
  assign bus.ram_wr_o    = presented ? sel_wr : '0;
  assign bus.ram_rd_o    = presented & sel_rd & ~(|sel_wr);
  assign bus.ram_len_o   = presented ? sel_len : '0;
  assign bus.ram_addr_o  = presented ? sel_addr : '0;
  assign bus.ram_wdata_o = presented ? sel_wdata : '0;

  assign busy_o      = ~rst & (~empty | presented);
  assign proto_err_o = ~rst & proto_err_q;

  always_comb begin
    st_d        = st_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    fifo_d      = fifo_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q;

    if (accept) begin
      st_d            = StIdle;
      rr_d            = (sel == IdW'(NReq - 1)) ? '0 : sel + 1'b1;
      fifo_d[wptr_q]  = sel;
      wptr_d          = wptr_q + 1'b1;
    end else if ((st_q == StIdle) && rr_found) begin
      st_d  = StLocked;
      gnt_d = rr_sel;
    end

    if (pop) rptr_d = rptr_q + 1'b1;

    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if ((bus.ram_ack_i & empty) | (presented & (|sel_wr) & sel_rd)) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      gnt_q       <= '0;
      rr_q        <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) fifo_q[i] <= '0;
    end else begin
      st_q        <= st_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
      fifo_q      <= fifo_d;
    end
  end

endmodule

// File: tb/tb_sdram_inport_arb.sv
module tb_sdram_inport_arb;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic proto_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sdram_inport_arb_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bif ();

  sdram_inport_arb #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .busy_o      (busy),
    .proto_err_o (proto_err)
  );

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    bif.req_wr_i     = '0;
    bif.req_rd_i     = '0;
    bif.req_len_i    = '0;
    bif.req_addr_i   = '0;
    bif.req_wdata_i  = '0;
    bif.ram_accept_i = 1'b0;
    bif.ram_ack_i    = 1'b0;
    bif.ram_error_i  = 1'b0;
    bif.ram_rdata_i  = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bif.req_rd_i  = 2'b11;
    bif.ram_ack_i = 1'b1;
    #1;
    checks++;
    if (bif.ram_rd_o !== 1'b0 || bif.req_ack_o !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%0b ack=%b busy=%0b, want 0/00/0",
               bif.ram_rd_o, bif.req_ack_o, busy);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (proto_err !== 1'b0 || dut.count_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got perr=%0b count=%0d, want 0/0", proto_err, dut.count_q);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bif.req_rd_i = 2'b10;
    bif.req_addr_i[63:32] = 32'h100;
    bif.req_len_i[15:8] = 8'd3;
    #1;
    checks++;
    if (bif.ram_rd_o !== 1'b1 || bif.ram_addr_o !== 32'h100 || bif.ram_len_o !== 8'd3 ||
        bif.req_accept_o !== 2'b00) begin
      errors++;
      $display("FAIL single_present: got rd=%0b addr=%h len=%0d acc=%b, want 1/100/3/00",
               bif.ram_rd_o, bif.ram_addr_o, bif.ram_len_o, bif.req_accept_o);
    end
    @(negedge clk);
    bif.ram_accept_i = 1'b1;
    #1;
    checks++;
    if (bif.req_accept_o !== 2'b10) begin
      errors++;
      $display("FAIL single_accept: got %b want 10", bif.req_accept_o);
    end
    @(negedge clk);
    clear_inputs();
    bif.ram_ack_i   = 1'b1;
    bif.ram_rdata_i = 32'hCAFEF00D;
    #1;
    checks++;
    if (bif.req_ack_o !== 2'b10 || bif.req_rdata_o !== 32'hCAFEF00D ||
        bif.req_error_o !== 2'b00) begin
      errors++;
      $display("FAIL single_ack: got ack=%b data=%h err=%b, want 10/cafef00d/00",
               bif.req_ack_o, bif.req_rdata_o, bif.req_error_o);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_gnt [4];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bif.req_rd_i     = 2'b11;
      bif.ram_accept_i = 1'b1;
      #1;
      checks++;
      if (bif.req_accept_o !== exp_gnt[c]) begin
        errors++;
        $display("FAIL alt_grant%0d: got %b want %b", c, bif.req_accept_o, exp_gnt[c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_inputs();
      bif.ram_ack_i   = 1'b1;
      bif.ram_error_i = (c == 2);
      #1;
      checks++;
      if (bif.req_ack_o !== exp_gnt[c] || bif.req_error_o !== ((c == 2) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL alt_ack%0d: got ack=%b err=%b want %b", c, bif.req_ack_o,
                 bif.req_error_o, exp_gnt[c]);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lock();
    bif.req_addr_i = {32'h300, 32'h200};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bif.req_rd_i = (c == 0) ? 2'b01 : 2'b11;
      #1;
      checks++;
      if (bif.ram_addr_o !== 32'h200 || bif.req_accept_o !== 2'b00) begin
        errors++;
        $display("FAIL lock_hold%0d: got addr=%h acc=%b want 200/00", c, bif.ram_addr_o,
                 bif.req_accept_o);
      end
    end
    @(negedge clk);
    bif.ram_accept_i = 1'b1;
    #1;
    checks++;
    if (bif.req_accept_o !== 2'b01) begin
      errors++;
      $display("FAIL lock_accept0: got %b want 01", bif.req_accept_o);
    end
    @(negedge clk);
    bif.req_rd_i = 2'b10;
    #1;
    checks++;
    if (bif.req_accept_o !== 2'b10 || bif.ram_addr_o !== 32'h300) begin
      errors++;
      $display("FAIL lock_next1: got acc=%b addr=%h want 10/300", bif.req_accept_o,
               bif.ram_addr_o);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      clear_inputs();
      bif.ram_ack_i = 1'b1;
      #1;
      checks++;
      if (bif.req_ack_o !== ((c == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL lock_ack%0d: got %b", c, bif.req_ack_o);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_full();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bif.req_rd_i     = 2'b01;
      bif.ram_accept_i = 1'b1;
      #1;
      checks++;
      if (bif.req_accept_o !== 2'b01) begin
        errors++;
        $display("FAIL full_fill%0d: got %b want 01", c, bif.req_accept_o);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bif.ram_rd_o !== 1'b0 || bif.req_accept_o !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_block: got rd=%0b acc=%b busy=%0b want 0/00/1", bif.ram_rd_o,
               bif.req_accept_o, busy);
    end
    @(negedge clk);
    bif.ram_ack_i = 1'b1;
    #1;
    checks++;
    if (bif.ram_rd_o !== 1'b0 || bif.req_ack_o !== 2'b01) begin
      errors++;
      $display("FAIL full_pop_cycle: got rd=%0b ack=%b want 0/01", bif.ram_rd_o, bif.req_ack_o);
    end
    @(negedge clk);
    bif.ram_ack_i = 1'b0;
    #1;
    checks++;
    if (bif.ram_rd_o !== 1'b1 || bif.req_accept_o !== 2'b01) begin
      errors++;
      $display("FAIL full_resume: got rd=%0b acc=%b want 1/01", bif.ram_rd_o, bif.req_accept_o);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_inputs();
      bif.ram_ack_i = 1'b1;
      #1;
      checks++;
      if (bif.req_ack_o !== 2'b01) begin
        errors++;
        $display("FAIL full_drain%0d: got %b want 01", c, bif.req_ack_o);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    bif.req_rd_i     = 2'b10;
    bif.ram_accept_i = 1'b1;
    @(negedge clk);
    bif.req_rd_i     = 2'b01;
    @(negedge clk);
    bif.req_rd_i     = 2'b10;
    bif.ram_ack_i    = 1'b1;
    bif.ram_rdata_i  = 32'h1234;
    #1;
    checks++;
    if (bif.req_accept_o !== 2'b10 || bif.req_ack_o !== 2'b10 ||
        bif.req_rdata_o !== 32'h1234) begin
      errors++;
      $display("FAIL pushpop_same: got acc=%b ack=%b data=%h want 10/10/1234",
               bif.req_accept_o, bif.req_ack_o, bif.req_rdata_o);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (dut.count_q !== 3'd2) begin
      errors++;
      $display("FAIL pushpop_count: got %0d want 2", dut.count_q);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bif.ram_ack_i = 1'b1;
      #1;
      checks++;
      if (bif.req_ack_o !== ((c == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL pushpop_drain%0d: got %b", c, bif.req_ack_o);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_proto_err_reset();
    @(negedge clk);
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_clean: got %0b want 0", proto_err);
    end
    @(negedge clk);
    bif.ram_ack_i = 1'b1;
    #1;
    checks++;
    if (bif.req_ack_o !== 2'b00) begin
      errors++;
      $display("FAIL perr_empty_ack: got %b want 00", bif.req_ack_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if (proto_err !== 1'b1) begin
        errors++;
        $display("FAIL perr_sticky%0d: got %0b want 1", c, proto_err);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bif.req_rd_i     = 2'b11;
      bif.ram_accept_i = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    bif.ram_ack_i = 1'b1;
    bif.ram_rdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (bif.ram_rd_o !== 1'b0 || bif.req_accept_o !== 2'b00 || bif.req_ack_o !== 2'b00 ||
        bif.req_rdata_o !== 32'h0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got rd=%0b acc=%b ack=%b data=%h busy=%0b perr=%0b want zeros",
               bif.ram_rd_o, bif.req_accept_o, bif.req_ack_o, bif.req_rdata_o, busy, proto_err);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (dut.count_q !== 3'd0 || proto_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got count=%0d perr=%0b busy=%0b want 0/0/0", dut.count_q,
               proto_err, busy);
    end
  endtask

  task automatic test_write_wins();
    @(negedge clk);
    bif.req_wr_i[3:0]     = 4'hF;
    bif.req_rd_i          = 2'b01;
    bif.req_wdata_i[31:0] = 32'h55AA55AA;
    #1;
    checks++;
    if (bif.ram_wr_o !== 4'hF || bif.ram_rd_o !== 1'b0 || bif.ram_wdata_o !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL wr_wins: got wr=%h rd=%0b wdata=%h want f/0/55aa55aa", bif.ram_wr_o,
               bif.ram_rd_o, bif.ram_wdata_o);
    end
    @(negedge clk);
    bif.ram_accept_i = 1'b1;
    #1;
    checks++;
    if (proto_err !== 1'b1 || bif.req_accept_o !== 2'b01) begin
      errors++;
      $display("FAIL wr_wins_perr: got perr=%0b acc=%b want 1/01", proto_err, bif.req_accept_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_full();
    test_push_pop();
    test_proto_err_reset();
    test_write_wins();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
